// File: rtl/j2_spi_boot.sv
// Power-on boot loader: copies a program image from SPI NOR flash (READ 0x03)
// into the j2 instruction RAM, holding the core in reset until the copy completes.
module j2_spi_boot #(
    parameter int          WORDS      = 8192,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 2
) (
    input  logic        clock,
    input  logic        active_low_reset,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        ram_write_enable,
    output logic [12:0] ram_address,
    output logic [15:0] ram_write_data,
    output logic        core_reset_n,
    output logic        boot_done
);

    localparam int             DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [17:0]    LAST_BIT     = 18'(32 + 16 * WORDS - 1);
    localparam logic [17:0]    LAST_CMD_BIT = 18'd31;
    localparam logic [31:0]    CMD_WORD     = {8'h03, FLASH_BASE};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic           idle_seen_r;
    logic [DW-1:0]  div_cnt_r;
    logic [17:0]    bit_cnt_r;
    logic [31:0]    cmd_sr_r;
    logic [15:0]    rx_sr_r;
    logic           spi_cs_n_r;
    logic           spi_sck_r;
    logic           spi_mosi_r;
    logic           ram_write_enable_r;
    logic [12:0]    ram_address_r;
    logic [15:0]    ram_write_data_r;
    logic           core_reset_n_r;
    logic           boot_done_r;

    logic           shifting_s;
    logic           tick_s;
    logic           rise_s;
    logic           fall_s;
    logic           word_done_s;

    assign shifting_s  = (state_r == CMD) || (state_r == DATA);
    assign tick_s      = (div_cnt_r == DIV_LAST);
    assign rise_s      = shifting_s && tick_s && !spi_sck_r;
    assign fall_s      = shifting_s && tick_s && spi_sck_r;
    // The 16th bit of every data word lands on bit counts ending in 4'hF.
    assign word_done_s = rise_s && (state_r == DATA) && (bit_cnt_r[3:0] == 4'hF);

    // State register.
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; transitions happen at the end of a bit's high phase.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (idle_seen_r) next_state_s = CMD;
                else             next_state_s = IDLE;
            end
            CMD: begin
                if (fall_s && (bit_cnt_r == LAST_CMD_BIT)) next_state_s = DATA;
                else                                       next_state_s = CMD;
            end
            DATA: begin
                if (fall_s && (bit_cnt_r == LAST_BIT)) next_state_s = DONE;
                else                                   next_state_s = DATA;
            end
            DONE:    next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // SPI shifting, RAM write strobe and release outputs.
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            idle_seen_r        <= 1'b0;
            div_cnt_r          <= '0;
            bit_cnt_r          <= 18'd0;
            cmd_sr_r           <= 32'd0;
            rx_sr_r            <= 16'd0;
            spi_cs_n_r         <= 1'b1;
            spi_sck_r          <= 1'b0;
            spi_mosi_r         <= 1'b0;
            ram_write_enable_r <= 1'b0;
            ram_address_r      <= 13'd0;
            ram_write_data_r   <= 16'd0;
            core_reset_n_r     <= 1'b0;
            boot_done_r        <= 1'b0;
        end else begin
            ram_write_enable_r <= word_done_s;
            if (word_done_s) begin
                ram_write_data_r <= {rx_sr_r[14:0], spi_miso};
            end
            if (ram_write_enable_r) begin
                ram_address_r <= ram_address_r + 13'd1;
            end
            case (state_r)
                IDLE: begin
                    idle_seen_r <= 1'b1;
                    if (idle_seen_r) begin
                        spi_cs_n_r <= 1'b0;
                        spi_sck_r  <= 1'b0;
                        spi_mosi_r <= CMD_WORD[31];
                        cmd_sr_r   <= {CMD_WORD[30:0], 1'b0};
                        div_cnt_r  <= '0;
                        bit_cnt_r  <= 18'd0;
                    end
                end
                CMD, DATA: begin
                    if (tick_s) begin
                        div_cnt_r <= '0;
                        if (!spi_sck_r) begin
                            spi_sck_r <= 1'b1;
                            rx_sr_r   <= {rx_sr_r[14:0], spi_miso};
                        end else begin
                            spi_sck_r <= 1'b0;
                            if (bit_cnt_r == LAST_BIT) begin
                                spi_cs_n_r     <= 1'b1;
                                spi_mosi_r     <= 1'b0;
                                core_reset_n_r <= 1'b1;
                                boot_done_r    <= 1'b1;
                            end else begin
                                // Zeros shift in behind the command, so MOSI idles low in DATA.
                                bit_cnt_r  <= bit_cnt_r + 18'd1;
                                spi_mosi_r <= cmd_sr_r[31];
                                cmd_sr_r   <= {cmd_sr_r[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                default: begin
                    idle_seen_r <= idle_seen_r;
                end
            endcase
        end
    end

    assign spi_cs_n         = spi_cs_n_r;
    assign spi_sck          = spi_sck_r;
    assign spi_mosi         = spi_mosi_r;
    assign ram_write_enable = ram_write_enable_r;
    assign ram_address      = ram_address_r;
    assign ram_write_data   = ram_write_data_r;
    assign core_reset_n     = core_reset_n_r;
    assign boot_done        = boot_done_r;

endmodule

// File: tb/tb_j2_spi_boot.sv
// Directed bench for j2_spi_boot: three configurations run side by side against
// a behavioural SPI flash model, followed by a mid-boot reset of the first one.
module tb_j2_spi_boot;

    logic clock = 1'b0;
    logic active_low_reset = 1'b0;
    int   ecount = -1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    // Index of the latest rising edge since reset release (first edge is 0).
    always @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) ecount <= -1;
        else                   ecount <= ecount + 1;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int          WD   = (gi == 0) ? 4 : (gi == 1) ? 1 : 2;
        localparam int          DV   = (gi == 2) ? 1 : 2;
        localparam logic [23:0] BASE = (gi == 1) ? 24'h012340 : 24'h000000;
        localparam logic [63:0] IMG  = (gi == 0) ? 64'h80050123FFFF6000 :
                                       (gi == 1) ? 64'hA55A000000000000 :
                                                   64'h1234ABCD00000000;
        logic        cs_n, sck, mosi, miso, we, crn, done;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic [63:0] img_v;
        int          fcnt = 0;
        logic [31:0] cmd_cap = 32'd0;

        j2_spi_boot #(.WORDS(WD), .FLASH_BASE(BASE), .CLK_DIV(DV)) u_dut (
            .clock(clock), .active_low_reset(active_low_reset),
            .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso),
            .ram_write_enable(we), .ram_address(addr), .ram_write_data(wdata),
            .core_reset_n(crn), .boot_done(done)
        );

        assign img_v = IMG;
        assign miso  = (fcnt >= 32 && fcnt < 32 + 16 * WD) ? img_v[63 - (fcnt - 32)] : 1'b0;

        // Flash model: counts SCK rises per transaction and captures the command.
        always @(posedge sck or posedge cs_n) begin
            if (cs_n) begin
                fcnt <= 0;
            end else begin
                fcnt <= fcnt + 1;
                if (fcnt < 32) cmd_cap <= {cmd_cap[30:0], mosi};
            end
        end

        logic        prev_we = 1'b0, prev_sck = 1'b0, prev_cs = 1'b1;
        int          wn = 0, width_err = 0, late_wr = 0, cs_rises = 0, sck_rises = 0;
        int          first_rise = -1, second_rise = -1, done_edge = -1;
        logic [12:0] wa [8];
        logic [15:0] wd [8];
        int          we_edge [8];

        // Monitor sampled on the falling edge, away from DUT updates.
        always @(negedge clock) begin
            if (!active_low_reset) begin
                wn <= 0; width_err <= 0; late_wr <= 0; cs_rises <= 0; sck_rises <= 0;
                first_rise <= -1; second_rise <= -1; done_edge <= -1;
                prev_we <= 1'b0; prev_sck <= 1'b0; prev_cs <= 1'b1;
            end else begin
                prev_we  <= we;
                prev_sck <= sck;
                prev_cs  <= cs_n;
                if (we) begin
                    if (wn < 8) begin
                        wa[wn[2:0]]      <= addr;
                        wd[wn[2:0]]      <= wdata;
                        we_edge[wn[2:0]] <= ecount;
                    end
                    wn <= wn + 1;
                    if (prev_we) width_err <= width_err + 1;
                    if (crn)     late_wr   <= late_wr + 1;
                end
                if (cs_n && !prev_cs) cs_rises <= cs_rises + 1;
                if (sck && !prev_sck) begin
                    sck_rises <= sck_rises + 1;
                    if (first_rise < 0)       first_rise  <= ecount;
                    else if (second_rise < 0) second_rise <= ecount;
                end
                if (done && done_edge < 0) done_edge <= ecount;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_edges(input int n);
        for (int e = 0; e < n; e++) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_cs_n",  32'(g_inst[0].cs_n),  32'd1);
        check("rst_sck",   32'(g_inst[0].sck),   32'd0);
        check("rst_mosi",  32'(g_inst[0].mosi),  32'd0);
        check("rst_we",    32'(g_inst[0].we),    32'd0);
        check("rst_addr",  32'(g_inst[0].addr),  32'd0);
        check("rst_wdata", 32'(g_inst[0].wdata), 32'd0);
        check("rst_crn",   32'(g_inst[0].crn),   32'd0);
        check("rst_done",  32'(g_inst[0].done),  32'd0);

        // Full boot of all three configurations
        active_low_reset = 1'b1;
        run_edges(420);

        check("basic_cmd",        g_inst[0].cmd_cap,            32'h03000000);
        check("basic_done_edge",  32'(g_inst[0].done_edge),     32'd385);
        check("basic_crn",        32'(g_inst[0].crn),           32'd1);
        check("basic_done",       32'(g_inst[0].done),          32'd1);
        check("basic_cs_n_end",   32'(g_inst[0].cs_n),          32'd1);
        check("basic_cs_rises",   32'(g_inst[0].cs_rises),      32'd1);
        check("basic_sck_rises",  32'(g_inst[0].sck_rises),     32'd96);
        check("basic_first_rise", 32'(g_inst[0].first_rise),    32'd3);
        check("basic_writes",     32'(g_inst[0].wn),            32'd4);
        check("basic_a0",         32'(g_inst[0].wa[0]),         32'd0);
        check("basic_d0",         32'(g_inst[0].wd[0]),         32'h8005);
        check("basic_e0",         32'(g_inst[0].we_edge[0]),    32'd191);
        check("basic_a1",         32'(g_inst[0].wa[1]),         32'd1);
        check("basic_d1",         32'(g_inst[0].wd[1]),         32'h0123);
        check("basic_e1",         32'(g_inst[0].we_edge[1]),    32'd255);
        check("basic_a2",         32'(g_inst[0].wa[2]),         32'd2);
        check("basic_d2",         32'(g_inst[0].wd[2]),         32'hFFFF);
        check("basic_e2",         32'(g_inst[0].we_edge[2]),    32'd319);
        check("basic_a3",         32'(g_inst[0].wa[3]),         32'd3);
        check("basic_d3",         32'(g_inst[0].wd[3]),         32'h6000);
        check("basic_e3",         32'(g_inst[0].we_edge[3]),    32'd383);
        check("basic_width_err",  32'(g_inst[0].width_err),     32'd0);
        check("basic_late_wr",    32'(g_inst[0].late_wr),       32'd0);

        check("base_cmd",         g_inst[1].cmd_cap,            32'h03012340);
        check("base_done_edge",   32'(g_inst[1].done_edge),     32'd193);
        check("base_writes",      32'(g_inst[1].wn),            32'd1);
        check("base_a0",          32'(g_inst[1].wa[0]),         32'd0);
        check("base_d0",          32'(g_inst[1].wd[0]),         32'hA55A);
        check("base_e0",          32'(g_inst[1].we_edge[0]),    32'd191);

        check("fast_cmd",         g_inst[2].cmd_cap,            32'h03000000);
        check("fast_done_edge",   32'(g_inst[2].done_edge),     32'd129);
        check("fast_first_rise",  32'(g_inst[2].first_rise),    32'd2);
        check("fast_second_rise", 32'(g_inst[2].second_rise),   32'd4);
        check("fast_sck_rises",   32'(g_inst[2].sck_rises),     32'd64);
        check("fast_writes",      32'(g_inst[2].wn),            32'd2);
        check("fast_d0",          32'(g_inst[2].wd[0]),         32'h1234);
        check("fast_e0",          32'(g_inst[2].we_edge[0]),    32'd96);
        check("fast_a1",          32'(g_inst[2].wa[1]),         32'd1);
        check("fast_d1",          32'(g_inst[2].wd[1]),         32'hABCD);
        check("fast_e1",          32'(g_inst[2].we_edge[1]),    32'd128);
        check("fast_width_err",   32'(g_inst[2].width_err),     32'd0);
        check("fast_late_wr",     32'(g_inst[2].late_wr),       32'd0);

        // Reset mid-boot, during word 1 of the basic configuration
        active_low_reset = 1'b0;
        repeat (2) @(negedge clock);
        active_low_reset = 1'b1;
        for (int e = 0; e < 300 && ecount != 200; e++) begin
            @(posedge clock);
            #1;
        end
        check("mid_edge",   32'(ecount),           32'd200);
        check("mid_writes", 32'(g_inst[0].wn),     32'd1);
        check("mid_cs_n",   32'(g_inst[0].cs_n),   32'd0);
        active_low_reset = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(g_inst[0].cs_n), 32'd1);
        check("mid_rst_crn",  32'(g_inst[0].crn),  32'd0);
        check("mid_rst_we",   32'(g_inst[0].we),   32'd0);
        check("mid_rst_sck",  32'(g_inst[0].sck),  32'd0);
        check("mid_rst_addr", 32'(g_inst[0].addr), 32'd0);
        repeat (3) @(negedge clock);
        active_low_reset = 1'b1;
        run_edges(420);

        check("rb_cmd",       g_inst[0].cmd_cap,         32'h03000000);
        check("rb_done_edge", 32'(g_inst[0].done_edge),  32'd385);
        check("rb_writes",    32'(g_inst[0].wn),         32'd4);
        check("rb_a0",        32'(g_inst[0].wa[0]),      32'd0);
        check("rb_d0",        32'(g_inst[0].wd[0]),      32'h8005);
        check("rb_a3",        32'(g_inst[0].wa[3]),      32'd3);
        check("rb_d3",        32'(g_inst[0].wd[3]),      32'h6000);
        check("rb_cs_rises",  32'(g_inst[0].cs_rises),   32'd1);
        check("rb_late_wr",   32'(g_inst[0].late_wr),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
